// File: rtl/qpsk_pkg.sv
// Shared constants for the QPSK transmit pulse-shaping filter:
// default sizes, RRC coefficient set and ternary input encoding.
package qpsk_pkg;

   localparam int unsigned NTAPS  = 16;
   localparam int unsigned COEF_W = 10;
   localparam int unsigned OUT_W  = 14;

   typedef enum logic [1:0] {
      SYM_ZERO = 2'b00,
      SYM_POS  = 2'b01,
      SYM_RSVD = 2'b10,
      SYM_NEG  = 2'b11
   } sym_t;

   typedef logic signed [COEF_W-1:0] coef_t;

   // Symmetric root-raised-cosine taps, RRC_COEF[15-k] == RRC_COEF[k]
   localparam coef_t RRC_COEF [NTAPS] = '{
      -10'sd6,  -10'sd14, -10'sd10,  10'sd18,
       10'sd62,  10'sd160, 10'sd330, 10'sd511,
       10'sd511, 10'sd330, 10'sd160, 10'sd62,
       10'sd18, -10'sd10, -10'sd14, -10'sd6
   };

endpackage

// File: rtl/fir_branch.sv
// One filter branch: ternary delay line, coefficient select stage and a
// two-level registered adder tree (four partial sums, then the final sum).
module fir_branch #(
   parameter int unsigned NTAPS  = qpsk_pkg::NTAPS,
   parameter int unsigned COEF_W = qpsk_pkg::COEF_W,
   parameter int unsigned OUT_W  = qpsk_pkg::OUT_W
) (
   input  logic                    clk_fs,
   input  logic                    rst,
   input  logic [1:0]              data_in,
   output logic signed [OUT_W-1:0] data_out
);
   import qpsk_pkg::*;

   localparam int unsigned NGRP = 4;
   localparam int unsigned GRP  = NTAPS / NGRP;

   logic [1:0]              taps     [NTAPS];
   logic signed [OUT_W-1:0] prod     [NTAPS];
   logic signed [OUT_W-1:0] psum     [NGRP];
   logic signed [OUT_W-1:0] psum_nxt [NGRP];
   logic signed [OUT_W-1:0] sum_nxt;

   // Ternary taps turn each multiply into a select of +coef, -coef or 0
   function automatic logic signed [OUT_W-1:0] tap_term(input logic [1:0] s,
                                                         input logic signed [COEF_W-1:0] c);
      logic signed [OUT_W-1:0] ext;
      ext = {{(OUT_W-COEF_W){c[COEF_W-1]}}, c};
      case (s)
         SYM_POS: return ext;
         SYM_NEG: return -ext;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      for (int unsigned g = 0; g < NGRP; g++) begin
         psum_nxt[g] = '0;
         for (int unsigned j = 0; j < GRP; j++)
            psum_nxt[g] = psum_nxt[g] + prod[g*GRP + j];
      end
      sum_nxt = '0;
      for (int unsigned g = 0; g < NGRP; g++)
         sum_nxt = sum_nxt + psum[g];
   end

   always_ff @(posedge clk_fs) begin
      if (rst) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            taps[k] <= '0;
            prod[k] <= '0;
         end
         for (int unsigned g = 0; g < NGRP; g++)
            psum[g] <= '0;
         data_out <= '0;
      end else begin
         taps[0] <= data_in;
         for (int unsigned k = 1; k < NTAPS; k++)
            taps[k] <= taps[k-1];
         for (int unsigned k = 0; k < NTAPS; k++)
            prod[k] <= tap_term(taps[k], RRC_COEF[k]);
         for (int unsigned g = 0; g < NGRP; g++)
            psum[g] <= psum_nxt[g];
         data_out <= sum_nxt;
      end
   end

endmodule

// File: rtl/qpsk_shaping_fir.sv
// QPSK transmit pulse-shaping filter: two identical RRC branches (I, Q)
// with a fixed 3-cycle pipeline and a fill counter driving out_valid.
module qpsk_shaping_fir #(
   parameter int unsigned NTAPS  = qpsk_pkg::NTAPS,
   parameter int unsigned COEF_W = qpsk_pkg::COEF_W,
   parameter int unsigned OUT_W  = qpsk_pkg::OUT_W
) (
   input  logic                    clk_fs,
   input  logic                    rst,
   input  logic [1:0]              data_I_in,
   input  logic [1:0]              data_Q_in,
   output logic signed [OUT_W-1:0] data_I_out,
   output logic signed [OUT_W-1:0] data_Q_out,
   output logic                    out_valid
);
   import qpsk_pkg::*;

   localparam int unsigned FILL_MAX = NTAPS + 3;
   localparam int unsigned CNT_W    = $clog2(FILL_MAX + 1);

   logic [CNT_W-1:0] fill_cnt;

   // Saturates at NTAPS+3: delay line full plus the three pipeline stages
   always_ff @(posedge clk_fs) begin
      if (rst)
         fill_cnt <= '0;
      else if (fill_cnt != CNT_W'(FILL_MAX))
         fill_cnt <= fill_cnt + CNT_W'(1);
   end

   assign out_valid = (fill_cnt == CNT_W'(FILL_MAX));

   fir_branch #(
      .NTAPS  (NTAPS),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W)
   ) u_fir_i (
      .clk_fs   (clk_fs),
      .rst      (rst),
      .data_in  (data_I_in),
      .data_out (data_I_out)
   );

   fir_branch #(
      .NTAPS  (NTAPS),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W)
   ) u_fir_q (
      .clk_fs   (clk_fs),
      .rst      (rst),
      .data_in  (data_Q_in),
      .data_out (data_Q_out)
   );

endmodule

// File: tb/tb_qpsk_shaping_fir.sv
// Self-checking bench for qpsk_shaping_fir: behavioural convolution model
// over a queue of decoded input samples, plus literal impulse/peak checks.
`timescale 1ns/1ps
module tb_qpsk_shaping_fir;

   localparam int NT = 16;

   logic              clk_fs = 1'b0;
   logic              rst;
   logic [1:0]        data_I_in;
   logic [1:0]        data_Q_in;
   logic signed [13:0] data_I_out;
   logic signed [13:0] data_Q_out;
   logic              out_valid;

   int n_assert = 0;
   int n_fail   = 0;

   const int c [NT] = '{-6, -14, -10, 18, 62, 160, 330, 511,
                        511, 330, 160, 62, 18, -10, -14, -6};
   const int imp_tab [NT] = '{-6, -14, -10, 18, 62, 160, 330, 511,
                              511, 330, 160, 62, 18, -10, -14, -6};

   // newest sample at index 0; cleared by reset
   int hist_i [$];
   int hist_q [$];
   int edge_n = 0;

   qpsk_shaping_fir #(
      .NTAPS  (16),
      .COEF_W (10),
      .OUT_W  (14)
   ) dut (
      .clk_fs     (clk_fs),
      .rst        (rst),
      .data_I_in  (data_I_in),
      .data_Q_in  (data_Q_in),
      .data_I_out (data_I_out),
      .data_Q_out (data_Q_out),
      .out_valid  (out_valid)
   );

   always #50 clk_fs = ~clk_fs;

   function automatic int dec(input logic [1:0] s);
      if (s == 2'b01) return 1;
      if (s == 2'b11) return -1;
      return 0;
   endfunction

   // output after edge m = sum_k c[k] * x[m-3-k]
   function automatic int model(input int h [$]);
      int acc = 0;
      for (int k = 0; k < NT; k++)
         if (3 + k < h.size()) acc += c[k] * h[3 + k];
      return acc;
   endfunction

   task automatic check(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edge_n);
      end
   endtask

   task automatic tick(input logic r, input logic [1:0] i, input logic [1:0] q);
      rst       = r;
      data_I_in = i;
      data_Q_in = q;
      @(posedge clk_fs);
      if (r) begin
         hist_i.delete();
         hist_q.delete();
         edge_n = 0;
      end else begin
         hist_i.push_front(dec(i));
         hist_q.push_front(dec(q));
         if (hist_i.size() > NT + 4) void'(hist_i.pop_back());
         if (hist_q.size() > NT + 4) void'(hist_q.pop_back());
         edge_n++;
      end
      #1;
      check("i_out", int'(data_I_out), model(hist_i));
      check("q_out", int'(data_Q_out), model(hist_q));
      check("valid", int'(out_valid), (edge_n >= NT + 3) ? 1 : 0);
   endtask

   task automatic impulse_run(input string tag);
      for (int m = 1; m <= 22; m++) begin
         tick(1'b0, (m == 1) ? 2'b01 : 2'b00, 2'b00);
         if (m >= 4 && m <= 19)
            check({tag, "_tab"}, int'(data_I_out), imp_tab[m-4]);
         else
            check({tag, "_zero"}, int'(data_I_out), 0);
      end
   endtask

   initial begin
      logic [1:0] s_i, s_q;

      // reset held 3 cycles with +1 inputs
      for (int k = 0; k < 3; k++) tick(1'b1, 2'b01, 2'b01);

      // I impulse, edge-numbered from reset release
      impulse_run("imp");

      // negative Q impulse
      for (int m = 1; m <= 20; m++) begin
         tick(1'b0, 2'b00, (m == 1) ? 2'b11 : 2'b00);
         if (m >= 4 && m <= 19)
            check("negq_tab", int'(data_Q_out), -imp_tab[m-4]);
      end

      // full-scale: I matches coefficient signs, Q the inverse
      for (int k = NT - 1; k >= 0; k--)
         tick(1'b0, (c[k] < 0) ? 2'b11 : 2'b01, (c[k] < 0) ? 2'b01 : 2'b11);
      for (int m = 1; m <= 3; m++) tick(1'b0, 2'b00, 2'b00);
      check("peak_pos", int'(data_I_out), 2222);
      check("peak_neg", int'(data_Q_out), -2222);
      for (int m = 0; m < 18; m++) tick(1'b0, 2'b00, 2'b00);

      // zero-stuffed stream from a fresh reset; I fixed pattern, Q random
      tick(1'b1, 2'b00, 2'b00);
      for (int m = 1; m <= 48; m++) begin
         s_i = (m % 4 == 1) ? 2'b01 : ($urandom_range(0, 3) == 0 ? 2'b10 : 2'b00);
         s_q = (m % 4 == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b11)
                            : ($urandom_range(0, 3) == 0 ? 2'b10 : 2'b00);
         tick(1'b0, s_i, s_q);
         if (m >= 24) check("stuffed_per", int'(data_I_out), c[(m + 0) % 4] +
                            c[(m % 4) + 4] + c[(m % 4) + 8] + c[(m % 4) + 12]);
      end

      // random ternary stream on both branches
      for (int m = 0; m < 30; m++) begin
         s_i = 2'($urandom_range(0, 3));
         s_q = 2'($urandom_range(0, 3));
         tick(1'b0, s_i, s_q);
      end

      // one-cycle mid-stream reset, then the impulse run again
      tick(1'b1, 2'b01, 2'b11);
      check("rst_i_zero", int'(data_I_out), 0);
      check("rst_valid", int'(out_valid), 0);
      impulse_run("imp2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
